// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit 7-segment scan driver with a double-buffered value/mask and guard blanking.
// Optional blinking per digit is built when SEG_BLINK_EN is defined (adds the `blink` port).
module seg_scan_driver #(
    parameter int SCAN_DIV     = 25000,
    parameter int BLANK_CYC    = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] data,
    input  logic [3:0]  mask,
`ifdef SEG_BLINK_EN
    input  logic [3:0]  blink,
`endif
    output logic [3:0]  en,
    output logic [6:0]  m_disp,
    output logic        frame_tick,
    output logic        pending,
    output logic        dbg_state
);

    // Interface contract: load is a fire-and-forget strobe with no ready; it is accepted every cycle.

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] SHOW_FIRST = CNT_W'(BLANK_CYC);

    if (SCAN_DIV < BLANK_CYC + 1 || BLANK_CYC < 1 || BLINK_FRAMES < 1) begin : g_param_check
        $error("seg_scan_driver: illegal SCAN_DIV/BLANK_CYC/BLINK_FRAMES combination");
    end

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       digit;
    logic [1:0]       digit_nxt;
    logic [15:0]      shadow_data;
    logic [3:0]       shadow_mask;
    logic [15:0]      act_data;
    logic [3:0]       act_mask;
    logic             slot_end;
    logic             boundary;
    logic             dark;
    logic [3:0]       nib;
    logic [3:0]       en_nxt;
    logic [6:0]       seg_nxt;
    logic [3:0]       blink_dark;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

`ifdef SEG_BLINK_EN
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    logic [FRM_W-1:0] frm_cnt;
    logic             phase;

    // Phase only flips on a frame boundary, where the next slot is always a BLANK slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frm_cnt <= '0;
            phase   <= 1'b0;
        end else if (boundary) begin
            if (frm_cnt == FRM_LAST) begin
                frm_cnt <= '0;
                phase   <= ~phase;
            end else begin
                frm_cnt <= frm_cnt + 1'b1;
            end
        end
    end

    assign blink_dark = phase ? blink : 4'h0;
`else
    assign blink_dark = 4'h0;
`endif

    // Outputs are computed from the next cnt/digit so they land on the same edge as the state.
    always_comb begin
        slot_end  = (cnt == CNT_LAST);
        boundary  = slot_end && (digit == 2'd3);
        cnt_nxt   = slot_end ? '0 : cnt + 1'b1;
        digit_nxt = slot_end ? digit + 2'd1 : digit;
        state_nxt = (cnt_nxt < SHOW_FIRST) ? BLANK : SHOW;
        nib       = act_data[{digit_nxt, 2'b00} +: 4];
        dark      = act_mask[digit_nxt] | blink_dark[digit_nxt];
        en_nxt    = 4'h0;
        seg_nxt   = 7'h00;
        if (state_nxt == SHOW && !dark) begin
            en_nxt  = 4'b0001 << digit_nxt;
            seg_nxt = hex7(nib);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= BLANK;
            cnt         <= '0;
            digit       <= 2'd0;
            en          <= 4'h0;
            m_disp      <= 7'h00;
            frame_tick  <= 1'b0;
            pending     <= 1'b0;
            shadow_data <= 16'h0;
            shadow_mask <= 4'h0;
            act_data    <= 16'h0;
            act_mask    <= 4'hF;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            digit      <= digit_nxt;
            en         <= en_nxt;
            m_disp     <= seg_nxt;
            frame_tick <= boundary;
            // A load on the boundary edge wins over the transfer, deferring it one frame.
            if (load) begin
                shadow_data <= data;
                shadow_mask <= mask;
                pending     <= 1'b1;
            end else if (boundary && pending) begin
                act_data <= shadow_data;
                act_mask <= shadow_mask;
                pending  <= 1'b0;
            end
        end
    end

    assign dbg_state = (state == SHOW);

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with SCAN_DIV=8, BLANK_CYC=2 (32-cycle frames).
// Define SEG_BLINK_EN for both files to include the blink scenario.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data = 16'h0;
    logic [3:0]  mask = 4'h0;
`ifdef SEG_BLINK_EN
    logic [3:0]  blink = 4'h0;
`endif
    logic [3:0]  en;
    logic [6:0]  m_disp;
    logic        frame_tick;
    logic        pending;
    logic        dbg_state;

    int checks = 0;
    int errors = 0;
    int k = 0;  // posedges since the last reset release

    always #5 clk = ~clk;

    seg_scan_driver #(
        .SCAN_DIV(8),
        .BLANK_CYC(2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .data(data),
        .mask(mask),
`ifdef SEG_BLINK_EN
        .blink(blink),
`endif
        .en(en),
        .m_disp(m_disp),
        .frame_tick(frame_tick),
        .pending(pending),
        .dbg_state(dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        k = k + 1;
        @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] m);
        data = d;
        mask = m;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks += 5;
        if (en !== 4'h0) begin errors++; $display("FAIL reset_en got %b want 0000", en); end
        if (m_disp !== 7'h00) begin errors++; $display("FAIL reset_seg got %h want 00", m_disp); end
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", frame_tick); end
        if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", pending); end
        if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state got %b want 0", dbg_state); end
        rst = 1'b1;
        k = 0;
        // All-dark first frame: mask resets to F and nothing has been transferred.
        for (int i = 0; i < 32; i++) begin
            tick();
            checks += 4;
            if (en !== 4'h0) begin errors++; $display("FAIL dark_en k=%0d got %b want 0000", k, en); end
            if (m_disp !== 7'h00) begin errors++; $display("FAIL dark_seg k=%0d got %h want 00", k, m_disp); end
            if (frame_tick !== (k == 32)) begin errors++; $display("FAIL dark_tick k=%0d got %b want %b", k, frame_tick, k == 32); end
            if (dbg_state !== ((k % 8) >= 2)) begin errors++; $display("FAIL dark_state k=%0d got %b want %b", k, dbg_state, (k % 8) >= 2); end
        end
    endtask

    task automatic test_load_display();
        logic [6:0] tab [4];
        int c, d;
        tab = '{7'h3F, 7'h4F, 7'h77, 7'h06};
        do_load(16'h1A30, 4'h0);
        checks++;
        if (pending !== 1'b1) begin errors++; $display("FAIL load_pending got %b want 1", pending); end
        while (k % 32 != 0) begin
            tick();
            checks++;
            if (en !== 4'h0) begin errors++; $display("FAIL pre_xfer_en k=%0d got %b want 0000", k, en); end
        end
        checks += 2;
        if (frame_tick !== 1'b1) begin errors++; $display("FAIL xfer_tick got %b want 1", frame_tick); end
        if (pending !== 1'b0) begin errors++; $display("FAIL xfer_pending got %b want 0", pending); end
        for (int i = 0; i < 32; i++) begin
            tick();
            c = k % 8;
            d = (k / 8) % 4;
            checks += 3;
            if (en !== ((c < 2) ? 4'h0 : 4'(1 << d))) begin errors++; $display("FAIL show_en k=%0d got %b want %b", k, en, (c < 2) ? 4'h0 : 4'(1 << d)); end
            if (m_disp !== ((c < 2) ? 7'h00 : tab[d])) begin errors++; $display("FAIL show_seg k=%0d got %h want %h", k, m_disp, (c < 2) ? 7'h00 : tab[d]); end
            if (dbg_state !== (c >= 2)) begin errors++; $display("FAIL show_state k=%0d got %b want %b", k, dbg_state, c >= 2); end
        end
    endtask

    task automatic test_last_load_wins();
        int c, d;
        repeat (4) tick();
        do_load(16'h1111, 4'h0);
        repeat (5) tick();
        do_load(16'h2222, 4'h0);
        checks++;
        if (pending !== 1'b1) begin errors++; $display("FAIL lw_pending got %b want 1", pending); end
        while (k % 32 != 0) tick();
        checks++;
        if (pending !== 1'b0) begin errors++; $display("FAIL lw_xfer_pending got %b want 0", pending); end
        for (int i = 0; i < 32; i++) begin
            tick();
            c = k % 8;
            d = (k / 8) % 4;
            checks += 2;
            if (en !== ((c < 2) ? 4'h0 : 4'(1 << d))) begin errors++; $display("FAIL lw_en k=%0d got %b want %b", k, en, (c < 2) ? 4'h0 : 4'(1 << d)); end
            if (m_disp !== ((c < 2) ? 7'h00 : 7'h5B)) begin errors++; $display("FAIL lw_seg k=%0d got %h want %h", k, m_disp, (c < 2) ? 7'h00 : 7'h5B); end
        end
    endtask

    task automatic test_load_on_tick();
        logic [6:0] tab_new [4];
        logic [6:0] tab_late [4];
        int c, d;
        tab_new  = '{7'h06, 7'h5B, 7'h4F, 7'h66};
        tab_late = '{7'h7D, 7'h07, 7'h7F, 7'h6F};
        checks++;
        if (frame_tick !== 1'b1) begin errors++; $display("FAIL ot_tick got %b want 1", frame_tick); end
        do_load(16'h4321, 4'h0);
        checks++;
        if (pending !== 1'b1) begin errors++; $display("FAIL ot_pending got %b want 1", pending); end
        while (k % 32 != 0) begin
            tick();
            c = k % 8;
            checks++;
            if (m_disp !== ((c < 2) ? 7'h00 : 7'h5B)) begin errors++; $display("FAIL ot_old_seg k=%0d got %h want %h", k, m_disp, (c < 2) ? 7'h00 : 7'h5B); end
        end
        checks++;
        if (pending !== 1'b0) begin errors++; $display("FAIL ot_xfer_pending got %b want 0", pending); end
        for (int i = 0; i < 31; i++) begin
            tick();
            c = k % 8;
            d = (k / 8) % 4;
            checks++;
            if (m_disp !== ((c < 2) ? 7'h00 : tab_new[d])) begin errors++; $display("FAIL ot_new_seg k=%0d got %h want %h", k, m_disp, (c < 2) ? 7'h00 : tab_new[d]); end
        end
        // This load is sampled on the boundary edge itself.
        do_load(16'h9876, 4'h0);
        checks += 2;
        if (frame_tick !== 1'b1) begin errors++; $display("FAIL cb_tick got %b want 1", frame_tick); end
        if (pending !== 1'b1) begin errors++; $display("FAIL cb_pending got %b want 1", pending); end
        for (int i = 0; i < 32; i++) begin
            tick();
            c = k % 8;
            d = (k / 8) % 4;
            checks++;
            if (m_disp !== ((c < 2) ? 7'h00 : tab_new[d])) begin errors++; $display("FAIL cb_hold_seg k=%0d got %h want %h", k, m_disp, (c < 2) ? 7'h00 : tab_new[d]); end
        end
        checks++;
        if (pending !== 1'b0) begin errors++; $display("FAIL cb_xfer_pending got %b want 0", pending); end
        for (int i = 0; i < 32; i++) begin
            tick();
            c = k % 8;
            d = (k / 8) % 4;
            checks++;
            if (m_disp !== ((c < 2) ? 7'h00 : tab_late[d])) begin errors++; $display("FAIL cb_new_seg k=%0d got %h want %h", k, m_disp, (c < 2) ? 7'h00 : tab_late[d]); end
        end
    endtask

    task automatic test_mask();
        logic [3:0] en_tab [4];
        logic [6:0] seg_tab [4];
        int c, d, gap;
        en_tab  = '{4'b0000, 4'b0010, 4'b0000, 4'b1000};
        seg_tab = '{7'h00, 7'h79, 7'h00, 7'h7C};
        do_load(16'hBEEF, 4'b0101);
        while (k % 32 != 0) tick();
        for (int i = 0; i < 32; i++) begin
            tick();
            c = k % 8;
            d = (k / 8) % 4;
            checks += 3;
            if (en === 4'b0001 || en === 4'b0100) begin errors++; $display("FAIL mask_forbidden k=%0d got %b want not 0001/0100", k, en); end
            if (en !== ((c < 2) ? 4'h0 : en_tab[d])) begin errors++; $display("FAIL mask_en k=%0d got %b want %b", k, en, (c < 2) ? 4'h0 : en_tab[d]); end
            if (m_disp !== ((c < 2) ? 7'h00 : seg_tab[d])) begin errors++; $display("FAIL mask_seg k=%0d got %h want %h", k, m_disp, (c < 2) ? 7'h00 : seg_tab[d]); end
        end
        gap = 0;
        do begin
            tick();
            gap++;
        end while (frame_tick !== 1'b1 && gap < 64);
        checks++;
        if (gap != 32) begin errors++; $display("FAIL tick_period got %0d want 32", gap); end
    endtask

    task automatic test_mid_reset();
        do_load(16'h5555, 4'h0);
        repeat (11) tick();
        checks += 2;
        if (en !== 4'b0010) begin errors++; $display("FAIL pre_rst_en got %b want 0010", en); end
        if (pending !== 1'b1) begin errors++; $display("FAIL pre_rst_pending got %b want 1", pending); end
        #2 rst = 1'b0;
        #1;
        checks += 5;
        if (en !== 4'h0) begin errors++; $display("FAIL mid_rst_en got %b want 0000", en); end
        if (m_disp !== 7'h00) begin errors++; $display("FAIL mid_rst_seg got %h want 00", m_disp); end
        if (pending !== 1'b0) begin errors++; $display("FAIL mid_rst_pending got %b want 0", pending); end
        if (frame_tick !== 1'b0) begin errors++; $display("FAIL mid_rst_tick got %b want 0", frame_tick); end
        if (dbg_state !== 1'b0) begin errors++; $display("FAIL mid_rst_state got %b want 0", dbg_state); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        k = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            checks += 3;
            if (en !== 4'h0) begin errors++; $display("FAIL post_rst_en k=%0d got %b want 0000", k, en); end
            if (pending !== 1'b0) begin errors++; $display("FAIL post_rst_pending k=%0d got %b want 0", k, pending); end
            if (frame_tick !== (k == 32)) begin errors++; $display("FAIL post_rst_tick k=%0d got %b want %b", k, frame_tick, k == 32); end
        end
    endtask

`ifdef SEG_BLINK_EN
    task automatic test_blink();
        int c, d, f;
        logic off;
        blink = 4'b1000;
        do_load(16'h8888, 4'h0);
        while (k % 32 != 0) tick();
        // Boundaries at 32, 64, ... since reset: phase is 1 for frames 2-3, 6-7, ...
        for (int i = 0; i < 128; i++) begin
            tick();
            c = k % 8;
            d = (k / 8) % 4;
            f = k / 32;
            off = (c < 2) || (d == 3 && ((f / 2) % 2 == 1));
            checks += 2;
            if (en !== (off ? 4'h0 : 4'(1 << d))) begin errors++; $display("FAIL blink_en k=%0d got %b want %b", k, en, off ? 4'h0 : 4'(1 << d)); end
            if (m_disp !== (off ? 7'h00 : 7'h7F)) begin errors++; $display("FAIL blink_seg k=%0d got %h want %h", k, m_disp, off ? 7'h00 : 7'h7F); end
        end
        blink = 4'h0;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog timeout at k=%0d", k);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_display();
        test_last_load_wins();
        test_load_on_tick();
        test_mask();
        test_mid_reset();
`ifdef SEG_BLINK_EN
        test_blink();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
